// File: rtl/palette_fader_if.sv
// Bus bundle between the palette fader, its control registers and the
// source / live palette RAM ports. The fader is the master (initiator).
interface palette_fader_if;
  logic       start;
  logic [4:0] target_level;
  logic       step_tick;
  logic       busy;
  logic       done;
  logic [4:0] cur_level;
  logic [6:0] src_addr;
  logic [7:0] src_rddata;
  logic [6:0] pal_addr;
  logic [7:0] pal_wrdata;
  logic       pal_wren;

  modport master (
    input  start, target_level, step_tick, src_rddata,
    output busy, done, cur_level, src_addr, pal_addr, pal_wrdata, pal_wren
  );

  modport slave (
    output start, target_level, step_tick, src_rddata,
    input  busy, done, cur_level, src_addr, pal_addr, pal_wrdata, pal_wren
  );
endinterface

// File: rtl/palette_fader.sv
// Palette fade engine: copies the base palette into the live palette with
// every 4-bit colour component scaled by a brightness level of 0..16.
module palette_fader #(
  parameter int ENTRIES    = 64,
  parameter int INIT_LEVEL = 16
) (
  input logic             clk,
  input logic             reset_n,
  palette_fader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_RDL       = 3'd2,
    S_RDH       = 3'd3,
    S_WRL       = 3'd4,
    S_WRH       = 3'd5
  } state_t;

  localparam logic [5:0] LAST_N     = 6'(ENTRIES - 1);
  localparam logic [4:0] INIT_LVL   = 5'(INIT_LEVEL);
  localparam logic [4:0] FULL_LEVEL = 5'd16;

  state_t     state_r;
  logic [5:0] n_r;
  logic [4:0] tgt_r;
  logic [7:0] gb_r;
  logic [3:0] r_r;
  logic       busy_r;
  logic       done_r;
  logic [4:0] level_r;
  logic [6:0] src_addr_r;
  logic [6:0] pal_addr_r;
  logic [7:0] pal_wrdata_r;
  logic       pal_wren_r;

  logic [4:0] start_tgt_s;
  logic [5:0] n_inc_s;

  // 9-bit product, divided by 16 without rounding; level 16 passes c through
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    logic [8:0] prod;
    prod = {5'd0, c} * {4'd0, lvl};
    return prod[7:4];
  endfunction

  // Clamp the requested level and precompute the next entry index
  always_comb begin
    start_tgt_s = bus.target_level;
    if (bus.target_level > FULL_LEVEL) begin
      start_tgt_s = FULL_LEVEL;
    end else begin
      start_tgt_s = bus.target_level;
    end
    n_inc_s = n_r + 6'd1;
  end

  // Fade sequencer; every output is loaded for the state being entered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      n_r          <= 6'd0;
      tgt_r        <= 5'd0;
      gb_r         <= 8'd0;
      r_r          <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      level_r      <= INIT_LVL;
      src_addr_r   <= 7'd0;
      pal_addr_r   <= 7'd0;
      pal_wrdata_r <= 8'd0;
      pal_wren_r   <= 1'b0;
    end else begin
      done_r       <= 1'b0;
      src_addr_r   <= 7'd0;
      pal_addr_r   <= 7'd0;
      pal_wrdata_r <= 8'd0;
      pal_wren_r   <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            tgt_r  <= start_tgt_s;
            busy_r <= 1'b1;
            n_r    <= 6'd0;
            // Equal levels still run one pass to refresh the live palette
            if (start_tgt_s == level_r) begin
              state_r <= S_RDL;
            end else begin
              state_r <= S_WAIT_TICK;
            end
          end
        end
        S_WAIT_TICK: begin
          if (bus.step_tick) begin
            if (level_r < tgt_r) begin
              level_r <= level_r + 5'd1;
            end else begin
              level_r <= level_r - 5'd1;
            end
            n_r     <= 6'd0;
            state_r <= S_RDL;
          end
        end
        S_RDL: begin
          gb_r       <= bus.src_rddata;
          src_addr_r <= {n_r, 1'b1};
          state_r    <= S_RDH;
        end
        S_RDH: begin
          r_r          <= bus.src_rddata[3:0];
          pal_wren_r   <= 1'b1;
          pal_addr_r   <= {n_r, 1'b0};
          pal_wrdata_r <= {scale(gb_r[7:4], level_r), scale(gb_r[3:0], level_r)};
          state_r      <= S_WRL;
        end
        S_WRL: begin
          pal_wren_r   <= 1'b1;
          pal_addr_r   <= {n_r, 1'b1};
          pal_wrdata_r <= {4'h0, scale(r_r, level_r)};
          state_r      <= S_WRH;
        end
        S_WRH: begin
          if (n_r < LAST_N) begin
            n_r        <= n_inc_s;
            src_addr_r <= {n_inc_s, 1'b0};
            state_r    <= S_RDL;
          end else if (level_r == tgt_r) begin
            n_r     <= 6'd0;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            n_r     <= 6'd0;
            state_r <= S_WAIT_TICK;
          end
        end
        default: begin
          n_r     <= 6'd0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.cur_level  = level_r;
  assign bus.src_addr   = src_addr_r;
  assign bus.pal_addr   = pal_addr_r;
  assign bus.pal_wrdata = pal_wrdata_r;
  assign bus.pal_wren   = pal_wren_r;

endmodule

// File: tb/tb_palette_fader.sv
// Bench for palette_fader: a pass-offset reference model checked every cycle,
// plus directed fade scenarios with literal palette expectations.
module tb_palette_fader;
  localparam int ENTRIES  = 64;
  localparam int PASS_LEN = 4 * ENTRIES;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  palette_fader_if bus();

  palette_fader dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] src_mem [0:127];
  logic [7:0] pal_ram [0:127];
  assign bus.src_rddata = src_mem[bus.src_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_count = 0;
  int done_cnt = 0;

  // Reference model state: where we are in the fade, not how the DUT encodes it
  int m_level = 16;
  int m_tgt = 0;
  int m_busy = 0;
  int m_wait = 0;
  int m_in_pass = 0;
  int m_t = 0;
  int m_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int sc(input int c, input int l);
    return (c * l) / 16;
  endfunction

  // Live palette RAM plus write/done counters, sampled at the write edge
  initial forever begin
    @(posedge clk);
    if (bus.pal_wren) begin
      pal_ram[bus.pal_addr] = bus.pal_wrdata;
      wr_count++;
    end
    if (bus.done) done_cnt++;
  end

  // Model advance at each edge, then compare every output just after it
  initial forever begin
    int ph, ent, g, b, r;
    int e_src, e_wren, e_addr, e_data;
    logic [7:0] lo, hi;
    @(posedge clk);
    if (!reset_n) begin
      m_level = 16; m_tgt = 0; m_busy = 0; m_wait = 0;
      m_in_pass = 0; m_t = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_in_pass != 0) begin
        if (m_t == PASS_LEN - 1) begin
          m_in_pass = 0;
          if (m_level == m_tgt) begin
            m_busy = 0;
            m_done = 1;
          end else begin
            m_wait = 1;
          end
        end else begin
          m_t++;
        end
      end else if (m_wait != 0) begin
        if (bus.step_tick) begin
          m_level = (m_level < m_tgt) ? m_level + 1 : m_level - 1;
          m_wait = 0;
          m_in_pass = 1;
          m_t = 0;
        end
      end else if (m_busy == 0 && bus.start) begin
        m_tgt = (bus.target_level > 5'd16) ? 16 : int'(bus.target_level);
        m_busy = 1;
        if (m_tgt == m_level) begin
          m_in_pass = 1;
          m_t = 0;
        end else begin
          m_wait = 1;
        end
      end
    end
    #1;
    e_src = 0; e_wren = 0; e_addr = 0; e_data = 0;
    if (m_in_pass != 0) begin
      ph  = m_t % 4;
      ent = m_t / 4;
      lo = src_mem[2 * ent];
      hi = src_mem[2 * ent + 1];
      g = int'(lo[7:4]);
      b = int'(lo[3:0]);
      r = int'(hi[3:0]);
      case (ph)
        0: e_src = 2 * ent;
        1: e_src = 2 * ent + 1;
        2: begin
          e_wren = 1; e_addr = 2 * ent;
          e_data = sc(g, m_level) * 16 + sc(b, m_level);
        end
        default: begin
          e_wren = 1; e_addr = 2 * ent + 1;
          e_data = sc(r, m_level);
        end
      endcase
    end
    chk("busy", int'(bus.busy), m_busy);
    chk("done", int'(bus.done), m_done);
    chk("cur_level", int'(bus.cur_level), m_level);
    chk("src_addr", int'(bus.src_addr), e_src);
    chk("pal_wren", int'(bus.pal_wren), e_wren);
    chk("pal_addr", int'(bus.pal_addr), e_addr);
    chk("pal_wrdata", int'(bus.pal_wrdata), e_data);
  end

  task automatic pulse_start(input logic [4:0] tl, output int scyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.target_level = tl;
    @(posedge clk);
    #1 scyc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.step_tick = 1'b1;
    @(negedge clk);
    bus.step_tick = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout at cyc %0d: got no done within %0d cycles", cyc, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int s1, s2, dc, w0, d0, nz;
    bus.start = 1'b0;
    bus.target_level = 5'd0;
    bus.step_tick = 1'b0;
    for (int i = 0; i < 128; i++) begin
      src_mem[i] = 8'($urandom_range(0, 255));
      pal_ram[i] = 8'h55;
    end
    src_mem[0]  = 8'hFF;
    src_mem[1]  = 8'hAF;
    src_mem[10] = 8'h1F;
    src_mem[11] = 8'hAF;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_level", int'(bus.cur_level), 16);
    chk("rst_wren", int'(bus.pal_wren), 0);
    chk("rst_src_addr", int'(bus.src_addr), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Refresh pass at full brightness
    w0 = wr_count;
    pulse_start(5'd16, s1);
    wait_done(400, dc);
    chk("t1_latency", dc - s1, 256);
    chk("t1_writes", wr_count - w0, 128);
    chk("t1_byte10", int'(pal_ram[10]), 8'h1F);
    chk("t1_byte11", int'(pal_ram[11]), 8'h0F);

    // Two-step fade 16 -> 14
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    pulse_start(5'd14, s1);
    repeat (20) @(negedge clk);
    tick();
    repeat (300) @(negedge clk);
    chk("t2_level15", int'(bus.cur_level), 15);
    chk("t2_busy_mid", int'(bus.busy), 1);
    chk("t2_no_done", done_cnt - d0, 0);
    chk("t2_gb_15", int'(pal_ram[0]), 8'hEE);
    chk("t2_r_15", int'(pal_ram[1]), 8'h0E);
    tick();
    wait_done(400, dc);
    repeat (2) @(negedge clk);
    chk("t2_gb_14", int'(pal_ram[0]), 8'hDD);
    chk("t2_r_14", int'(pal_ram[1]), 8'h0D);
    chk("t2_level14", int'(bus.cur_level), 14);
    chk("t2_one_done", done_cnt - d0, 1);

    // Full fade to black with randomised tick spacing and palette
    do_reset();
    for (int i = 0; i < 128; i++) src_mem[i] = 8'($urandom_range(0, 255));
    w0 = wr_count;
    pulse_start(5'd0, s1);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(258, 320)) @(negedge clk);
      tick();
    end
    wait_done(400, dc);
    nz = 0;
    for (int i = 0; i < 128; i++) if (pal_ram[i] != 8'h00) nz++;
    chk("t3_nonzero_bytes", nz, 0);
    chk("t3_level0", int'(bus.cur_level), 0);
    chk("t3_busy", int'(bus.busy), 0);
    chk("t3_writes", wr_count - w0, 16 * 128);

    // Clamped target gives one refresh pass; a start while busy is ignored
    do_reset();
    w0 = wr_count;
    pulse_start(5'd31, s1);
    repeat (100) @(negedge clk);
    pulse_start(5'd3, s2);
    wait_done(400, dc);
    chk("t4_latency", dc - s1, 256);
    repeat (300) @(negedge clk);
    chk("t4_writes", wr_count - w0, 128);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_level", int'(bus.cur_level), 16);

    // Second tick during a pass is dropped
    pulse_start(5'd10, s1);
    repeat (10) @(negedge clk);
    tick();
    repeat (100) @(negedge clk);
    tick();
    repeat (400) @(negedge clk);
    chk("t5_level", int'(bus.cur_level), 15);
    chk("t5_busy", int'(bus.busy), 1);

    // Reset in the middle of a write
    tick();
    repeat (50) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      if (bus.pal_wren) break;
    end
    chk("t6_wren_before", int'(bus.pal_wren), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_wren_async", int'(bus.pal_wren), 0);
    chk("t6_busy_async", int'(bus.busy), 0);
    chk("t6_level_async", int'(bus.cur_level), 16);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    w0 = wr_count;
    repeat (300) @(negedge clk);
    chk("t6_no_writes", wr_count - w0, 0);
    chk("t6_busy_after", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
